// File: rtl/cdc_pkg.sv
// cdc_pkg: shared defaults and helpers for the toggle-handshake crossing blocks
//   SYNC_STAGES_DEF   default depth of the ack synchroniser chain
//   TIMEOUT_DEF       default in-flight cycle limit before timeout_err pulses (0 disables)
//   timeout_cnt_width width of a counter that can hold 0..timeout (never below 1 bit)
package cdc_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 1024;

    function automatic int timeout_cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/cdc_ack_sync.sv
// cdc_ack_sync: multi-flop synchroniser for the asynchronous ack toggle, cleared by rst
//   clk  in   source clock
//   rst  in   synchronous reset, active high; loads DEF into every stage
//   d    in   asynchronous level (ack_tgl from the destination domain)
//   q    out  d after STAGES flops in the clk domain
module cdc_ack_sync
    import cdc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF,
    parameter bit DEF    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // The chain is cleared together with the toggle register so a reset never
    // leaves a stale ack level that would look like a completion afterwards.
    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{DEF}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_toggle_tx.sv
// cdc_toggle_tx: transmit end of a toggle-handshake bus crossing with a 1-deep pending slot
//   clk          in   source clock
//   rst          in   synchronous reset, active high
//   in_valid     in   upstream word valid
//   in_data      in   upstream word
//   in_ready     out  pending slot free; a transfer happens on in_valid & in_ready
//   tx_req       out  request toggle to the destination (registered)
//   tx_data      out  launched word, stable from the tx_req toggle until its ack
//   ack_tgl      in   ack toggle from the destination (asynchronous)
//   busy         out  a word is in flight
//   done         out  one-cycle pulse when the in-flight word is acknowledged
//   timeout_err  out  one-cycle pulse, at most once per word, after TIMEOUT cycles in flight
module cdc_toggle_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             ack_tgl,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int            CW     = timeout_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic             ack_s;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_data;
    logic [WIDTH-1:0] next_data;
    logic [CW-1:0]    to_cnt;
    logic             accept;
    logic             complete;
    logic             launch;

    cdc_ack_sync #(
        .STAGES (SYNC_STAGES),
        .DEF    (1'b0)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (ack_tgl),
        .q   (ack_s)
    );

    assign in_ready = !rst && !pend_valid;
    assign accept   = in_valid && in_ready;

    // busy is the registered WAIT state; completion is the first edge at which the
    // synchronised ack has caught up with the toggle we sent.
    assign complete = busy && (ack_s == tx_req);

    // Launch straight from the input when idle, or at completion from the pending
    // slot (or from the input when the slot is empty) so there is no idle gap.
    assign launch    = (!busy && accept) || (complete && (pend_valid || accept));
    assign next_data = pend_valid ? pend_data : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_req      <= 1'b0;
            tx_data     <= '0;
            pend_valid  <= 1'b0;
            pend_data   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            done        <= complete;
            busy        <= launch || (busy && !complete);
            pend_valid  <= !launch && (pend_valid || accept);
            pend_data   <= (accept && !launch) ? in_data : pend_data;
            tx_data     <= launch ? next_data : tx_data;
            tx_req      <= launch ? !tx_req : tx_req;
            // Saturating counter: reaching the limit reports once, the transfer keeps waiting.
            to_cnt      <= launch ? '0 : (busy && to_cnt != T_MAX) ? to_cnt + 1'b1 : to_cnt;
            timeout_err <= (TIMEOUT > 0) && busy && !launch && (to_cnt == T_LAST);
        end
    end

endmodule

// File: tb/tb_cdc_toggle_tx.sv
// tb_cdc_toggle_tx: directed and random checks of the toggle-handshake transmitter
module tb_cdc_toggle_tx;

    localparam int SS = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       dclk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       ack_tgl = 1'b0;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic       hold = 1'b0;
    logic       r1 = 1'b0;
    logic       r2 = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         ack_cyc = 0;

    cdc_toggle_tx #(
        .WIDTH       (8),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .ack_tgl     (ack_tgl),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    // Source edges at even times, destination edges at odd times: they never coincide.
    always #10 clk = ~clk;
    always #13 dclk = ~dclk;

    // Receiver model: two-flop sync of tx_req, then echo it back as ack_tgl unless held.
    always @(posedge dclk) begin
        if (rst) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
            ack_tgl <= 1'b0;
        end else begin
            r1 <= tx_req;
            r2 <= r1;
            if (!hold) ack_tgl <= r2;
        end
    end

    always @(posedge clk) cyc++;
    always @(ack_tgl) ack_cyc = cyc;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got=%0h exp=0", tx_req); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got=%0h exp=0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%0h exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got=%0h exp=0", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got=%0h exp=0", timeout_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_in_rst: got=%0h exp=0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got=%0h exp=1", in_ready); end
    endtask

    task automatic test_single();
        int n;
        bit stable;
        in_valid = 1'b1;
        in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL single_tx_req: got=%0h exp=1", tx_req); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got=%0h exp=a5", tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got=%0h exp=1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_early: got=%0h exp=0", done); end
        n = 0;
        stable = 1'b1;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (tx_data !== 8'hA5) stable = 1'b0;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done_seen: got=%0h exp=1", done); end
        checks++; if (!stable) begin errors++; $display("FAIL single_tx_data_stable: got=%0h exp=a5", tx_data); end
        checks++; if (cyc - ack_cyc !== SS + 1) begin errors++; $display("FAIL single_ack_to_done: got=%0d exp=%0d", cyc - ack_cyc, SS + 1); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got=%0h exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got=%0h exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        logic [7:0] seq [$];
        logic [7:0] got;
        logic       prev_req;
        int         idx, n, ndone;
        bit         fire, gap_err;
        w[0] = 8'h11;
        w[1] = 8'h22;
        w[2] = 8'h33;
        idx = 0;
        n = 0;
        ndone = 0;
        gap_err = 1'b0;
        prev_req = tx_req;
        in_valid = 1'b1;
        in_data = w[0];
        while ((idx < 3 || busy === 1'b1) && n < 200) begin
            fire = in_valid && in_ready;
            tick();
            n++;
            if (fire) begin
                idx++;
                if (idx == 2) begin
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_pend_full_ready: got=%0h exp=0", in_ready); end
                    checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL b2b_first_held: got=%0h exp=11", tx_data); end
                end
                in_valid = (idx < 3);
                if (idx < 3) in_data = w[idx];
            end
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    checks++; if (idx !== 2) begin errors++; $display("FAIL b2b_ready_until_done: got=%0d exp=2", idx); end
                end
            end
            if (tx_req !== prev_req) begin
                seq.push_back(tx_data);
                if (seq.size() > 1 && done !== 1'b1) gap_err = 1'b1;
                prev_req = tx_req;
            end
        end
        in_valid = 1'b0;
        checks++; if (n >= 200) begin errors++; $display("FAIL b2b_timeout: got=%0d exp=<200", n); end
        checks++; if (seq.size() !== 3) begin errors++; $display("FAIL b2b_launch_count: got=%0d exp=3", seq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < seq.size()) ? seq[i] : 8'hxx;
            checks++; if (got !== w[i]) begin errors++; $display("FAIL b2b_seq%0d: got=%0h exp=%0h", i, got, w[i]); end
        end
        checks++; if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count: got=%0d exp=3", ndone); end
        checks++; if (gap_err) begin errors++; $display("FAIL b2b_no_gap: got=gap exp=toggle_with_done"); end
    endtask

    task automatic test_same_edge();
        int   n;
        logic prev_req;
        in_valid = 1'b1;
        in_data = 8'h40;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (ack_tgl !== tx_req && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n >= 100) begin errors++; $display("FAIL same_ack_wait: got=%0d exp=<100", n); end
        while (cyc < ack_cyc + SS) tick();
        prev_req = tx_req;
        in_valid = 1'b1;
        in_data = 8'h44;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_ready_before: got=%0h exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL same_done: got=%0h exp=1", done); end
        checks++; if (tx_data !== 8'h44) begin errors++; $display("FAIL same_tx_data: got=%0h exp=44", tx_data); end
        checks++; if (tx_req !== ~prev_req) begin errors++; $display("FAIL same_tx_req: got=%0h exp=%0h", tx_req, ~prev_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got=%0h exp=1", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL same_pend_empty: got=%0h exp=1", in_ready); end
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 100);
        checks++; if (done !== 1'b1 || tx_data !== 8'h44) begin errors++; $display("FAIL same_second_done: got=%0h/%0h exp=1/44", done, tx_data); end
        tick();
    endtask

    task automatic test_timeout();
        int   n0, n, pulses, pulse_cyc;
        logic prev_req;
        bit   chg;
        hold = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        n0 = cyc;
        prev_req = tx_req;
        pulses = 0;
        pulse_cyc = -1;
        chg = 1'b0;
        repeat (30) begin
            tick();
            if (timeout_err === 1'b1) begin
                pulses++;
                pulse_cyc = cyc;
            end
            if (tx_data !== 8'h55 || tx_req !== prev_req) chg = 1'b1;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_pulses: got=%0d exp=1", pulses); end
        checks++; if (pulse_cyc - n0 !== TO) begin errors++; $display("FAIL timeout_cycle: got=%0d exp=%0d", pulse_cyc - n0, TO); end
        checks++; if (chg) begin errors++; $display("FAIL timeout_held: got=%0h/%0h exp=55/%0h", tx_data, tx_req, prev_req); end
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL timeout_waiting: got=%0h/%0h exp=1/0", busy, done); end
        hold = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (timeout_err === 1'b1) pulses++;
        end
        checks++; if (done !== 1'b1 || tx_data !== 8'h55) begin errors++; $display("FAIL timeout_release_done: got=%0h/%0h exp=1/55", done, tx_data); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL timeout_once: got=%0d exp=1", pulses); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        bit active;
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        hold = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h66;
        tick();
        in_data = 8'h77;
        checks++; if (tx_req !== 1'b1 || tx_data !== 8'h66) begin errors++; $display("FAIL rmid_launch: got=%0h/%0h exp=1/66", tx_req, tx_data); end
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_pend_full: got=%0h exp=0", in_ready); end
        rst = 1'b1;
        tick();
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL rmid_tx_req: got=%0h exp=0", tx_req); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data: got=%0h exp=0", tx_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_flags: got=%0h%0h%0h exp=000", busy, done, timeout_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got=%0h exp=0", in_ready); end
        repeat (2) tick();
        hold = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got=%0h exp=1", in_ready); end
        active = 1'b0;
        repeat (10) begin
            tick();
            if (tx_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) active = 1'b1;
        end
        checks++; if (active) begin errors++; $display("FAIL rmid_discarded: got=activity exp=quiet"); end
        in_valid = 1'b1;
        in_data = 8'h88;
        tick();
        in_valid = 1'b0;
        checks++; if (tx_req !== 1'b1 || tx_data !== 8'h88) begin errors++; $display("FAIL rmid_relaunch: got=%0h/%0h exp=1/88", tx_req, tx_data); end
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_relaunch_done: got=%0h exp=1", done); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic [7:0] exp_data;
        logic       prev_req;
        logic [7:0] prev_data;
        int         nacc, nlaunch, ndone, n;
        bit         fire;
        nacc = 0;
        nlaunch = 0;
        ndone = 0;
        n = 0;
        prev_req = tx_req;
        prev_data = tx_data;
        in_valid = 1'b0;
        while ((nacc < 2000 || busy === 1'b1 || q.size() > 0) && n < 40000) begin
            fire = in_valid && in_ready;
            tick();
            n++;
            if (fire) begin
                q.push_back(in_data);
                nacc++;
            end
            if (done === 1'b1) ndone++;
            if (tx_req !== prev_req) begin
                nlaunch++;
                exp_data = (q.size() > 0) ? q.pop_front() : 8'hxx;
                checks++; if (tx_data !== exp_data) begin errors++; $display("FAIL rand_order: got=%0h exp=%0h", tx_data, exp_data); end
            end else begin
                checks++; if (tx_data !== prev_data) begin errors++; $display("FAIL rand_stable: got=%0h exp=%0h", tx_data, prev_data); end
            end
            prev_req = tx_req;
            prev_data = tx_data;
            hold = ($urandom_range(0, 3) == 0);
            if (!in_valid || fire) begin
                in_valid = (nacc < 2000) && ($urandom_range(0, 1) == 1);
                in_data = 8'($urandom);
            end
        end
        hold = 1'b0;
        in_valid = 1'b0;
        checks++; if (n >= 40000) begin errors++; $display("FAIL rand_timeout: got=%0d exp=<40000", n); end
        checks++; if (nlaunch !== 2000) begin errors++; $display("FAIL rand_launches: got=%0d exp=2000", nlaunch); end
        checks++; if (ndone !== 2000) begin errors++; $display("FAIL rand_dones: got=%0d exp=2000", ndone); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_edge();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
